// File: rtl/fwd_hazard_scoreboard.sv
// ID-stage forwarding selector and load-use interlock driven by a private shadow
// of the destination writes in flight in stages 1..NUM_STAGES after ID.
module fwd_hazard_scoreboard #(
  parameter int REG_ADDR_W     = 5,
  parameter int NUM_SRC        = 2,
  parameter int NUM_STAGES     = 3,
  parameter int LOAD_READY_STG = 2,
  parameter int CNT_W          = 16,
  parameter int SEL_W          = $clog2(NUM_STAGES + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_dst_addr,
  input  logic                          id_reg_write,
  input  logic                          id_is_load,
  input  logic                          pipe_advance,
  input  logic                          flush,
  input  logic                          cnt_clr,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          stall,
  output logic [CNT_W-1:0]              stall_count
);

  logic [NUM_STAGES:1]   sh_valid;
  logic [NUM_STAGES:1]   sh_wr;
  logic [NUM_STAGES:1]   sh_ld;
  logic [REG_ADDR_W-1:0] sh_dst [1:NUM_STAGES];

  logic [NUM_SRC-1:0]    hazard;
  logic                  issue;

  // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    logic [REG_ADDR_W-1:0] addr;
    logic                  found;
    logic                  win_ld;
    int                    win;
    fwd_sel = '0;
    hazard  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      addr   = id_src_addr[i*REG_ADDR_W +: REG_ADDR_W];
      found  = 1'b0;
      win    = 0;
      win_ld = 1'b0;
      // Scan oldest to youngest so the youngest match is the one left standing.
      for (int k = NUM_STAGES; k >= 1; k--) begin
        if (id_src_used[i] && addr != '0 && sh_valid[k] && sh_wr[k] && sh_dst[k] == addr) begin
          found  = 1'b1;
          win    = k;
          win_ld = sh_ld[k];
        end
      end
      if (found) begin
        if (!win_ld || win >= LOAD_READY_STG) fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(win);
        else                                  hazard[i] = 1'b1;
      end
    end
  end

  assign stall = id_valid & ~flush & (|hazard);
  assign issue = id_valid & ~stall & ~flush;

  // NOTE: sequential state uses non-blocking assignments so every stage shifts from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_valid    <= '0;
      stall_count <= '0;
    end else begin
      if (pipe_advance) begin
        sh_valid[1] <= issue;
        for (int k = 2; k <= NUM_STAGES; k++) sh_valid[k] <= sh_valid[k-1];
      end
      if (cnt_clr)
        stall_count <= '0;
      else if (stall && pipe_advance && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
    end
  end

  // NOTE: payload fields are not reset; a cleared valid bit makes them don't-care.
  always_ff @(posedge clk) begin
    if (pipe_advance) begin
      sh_dst[1] <= id_dst_addr;
      sh_wr[1]  <= id_reg_write;
      sh_ld[1]  <= id_is_load;
      for (int k = 2; k <= NUM_STAGES; k++) begin
        sh_dst[k] <= sh_dst[k-1];
        sh_wr[k]  <= sh_wr[k-1];
        sh_ld[k]  <= sh_ld[k-1];
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Bench for fwd_hazard_scoreboard: directed scenarios plus random traffic on two
// configurations, checked against an in-flight-list reference model.
module tb_fwd_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: default pipeline, 4-bit counter.
  logic        a_valid, a_wr, a_ld, a_adv, a_flush, a_clr, a_stall;
  logic [9:0]  a_src;
  logic [1:0]  a_used;
  logic [4:0]  a_dst;
  logic [3:0]  a_sel;
  logic [3:0]  a_cnt;

  // Instance B: 3 sources, 5 stages, loads ready from stage 4.
  logic        b_valid, b_wr, b_ld, b_adv, b_flush, b_clr, b_stall;
  logic [14:0] b_src;
  logic [2:0]  b_used;
  logic [4:0]  b_dst;
  logic [8:0]  b_sel;
  logic [15:0] b_cnt;

  fwd_hazard_scoreboard #(.CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(a_valid), .id_src_addr(a_src),
    .id_src_used(a_used), .id_dst_addr(a_dst), .id_reg_write(a_wr),
    .id_is_load(a_ld), .pipe_advance(a_adv), .flush(a_flush), .cnt_clr(a_clr),
    .fwd_sel(a_sel), .stall(a_stall), .stall_count(a_cnt));

  fwd_hazard_scoreboard #(.NUM_SRC(3), .NUM_STAGES(5), .LOAD_READY_STG(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(b_valid), .id_src_addr(b_src),
    .id_src_used(b_used), .id_dst_addr(b_dst), .id_reg_write(b_wr),
    .id_is_load(b_ld), .pipe_advance(b_adv), .flush(b_flush), .cnt_clr(b_clr),
    .fwd_sel(b_sel), .stall(b_stall), .stall_count(b_cnt));

  // Reference model: list of instructions in flight, index 0 = entered most recently.
  typedef struct {bit v; int dst; bit wr; bit ld;} ent_t;
  typedef ent_t ent_q_t[$];

  ent_q_t hq_a, hq_b;
  int     cnt_a, cnt_b;
  int     tests = 0;
  int     fails = 0;

  function automatic ent_q_t empty_q(input int n);
    ent_q_t r;
    for (int j = 0; j < n; j++) r.push_back('{v: 0, dst: 0, wr: 0, ld: 0});
    return r;
  endfunction

  function automatic ent_q_t advance(input ent_q_t h, input ent_t e);
    ent_q_t r = h;
    r.push_front(e);
    void'(r.pop_back());
    return r;
  endfunction

  // Youngest writer of addr decides: forward from its age, or hazard if its load data is not out yet.
  function automatic int pick(input ent_q_t h, input int addr, input bit used, input int rdy, output bit haz);
    haz = 1'b0;
    if (!used || addr == 0) return 0;
    for (int j = 0; j < h.size(); j++) begin
      if (h[j].v && h[j].wr && h[j].dst == addr) begin
        if (!h[j].ld || j + 1 >= rdy) return j + 1;
        haz = 1'b1;
        return 0;
      end
    end
    return 0;
  endfunction

  function automatic bit model_eval(input ent_q_t h, input int nsrc, input int rdy,
                                    input logic [14:0] src, input logic [2:0] used,
                                    input logic valid, input logic fl, output int sel[3]);
    bit any = 1'b0;
    bit hz;
    for (int i = 0; i < 3; i++) begin
      sel[i] = 0;
      if (i < nsrc) begin
        sel[i] = pick(h, int'(src[i*5 +: 5]), used[i], rdy, hz);
        any |= hz;
      end
    end
    return valid && !fl && any;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    int s[3];
    bit sa, sb;
    sa = model_eval(hq_a, 2, 2, {5'b0, a_src}, {1'b0, a_used}, a_valid, a_flush, s);
    sb = model_eval(hq_b, 3, 4, b_src, b_used, b_valid, b_flush, s);
    if (a_adv) hq_a = advance(hq_a, '{v: a_valid && !sa && !a_flush, dst: int'(a_dst), wr: a_wr, ld: a_ld});
    if (b_adv) hq_b = advance(hq_b, '{v: b_valid && !sb && !b_flush, dst: int'(b_dst), wr: b_wr, ld: b_ld});
    if (a_clr) cnt_a = 0; else if (sa && a_adv && cnt_a < 15) cnt_a++;
    if (b_clr) cnt_b = 0; else if (sb && b_adv && cnt_b < 65535) cnt_b++;
  endtask

  // Compare all outputs at the falling edge, then clock and advance the model.
  task automatic cycle();
    int sa[3], sb[3];
    bit ea, eb;
    @(negedge clk);
    ea = model_eval(hq_a, 2, 2, {5'b0, a_src}, {1'b0, a_used}, a_valid, a_flush, sa);
    eb = model_eval(hq_b, 3, 4, b_src, b_used, b_valid, b_flush, sb);
    for (int i = 0; i < 2; i++) check($sformatf("a_sel%0d", i), a_sel[i*2 +: 2], sa[i]);
    for (int i = 0; i < 3; i++) check($sformatf("b_sel%0d", i), b_sel[i*3 +: 3], sb[i]);
    check("a_stall", a_stall, ea);
    check("b_stall", b_stall, eb);
    check("a_cnt", a_cnt, cnt_a);
    check("b_cnt", b_cnt, cnt_b);
    @(posedge clk);
    step();
    #1;
  endtask

  task automatic set_a(input bit v, input logic [4:0] s0, input bit u0, input logic [4:0] s1,
                       input bit u1, input logic [4:0] d, input bit w, input bit l,
                       input bit adv = 1, input bit fl = 0, input bit clr = 0);
    a_valid = v; a_src = {s1, s0}; a_used = {u1, u0}; a_dst = d; a_wr = w; a_ld = l;
    a_adv = adv; a_flush = fl; a_clr = clr;
  endtask

  task automatic set_b(input bit v, input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] u, input logic [4:0] d, input bit w, input bit l);
    b_valid = v; b_src = {s2, s1, s0}; b_used = u; b_dst = d; b_wr = w; b_ld = l;
    b_adv = 1'b1; b_flush = 1'b0; b_clr = 1'b0;
  endtask

  task automatic alu_a(input logic [4:0] d);
    set_a(1, 0, 0, 0, 0, d, 1, 0);
  endtask

  task automatic rd_a(input logic [4:0] s0, input bit u0, input logic [4:0] s1, input bit u1);
    set_a(1, s0, u0, s1, u1, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_a_stall", a_stall, 0);
    check("rst_b_stall", b_stall, 0);
    check("rst_b_sel", b_sel, 0);
    check("rst_a_cnt", a_cnt, 0);
    rst_n = 1'b1;
    hq_a = empty_q(3); hq_b = empty_q(5); cnt_a = 0; cnt_b = 0;
    @(posedge clk);
    step();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_a(0, 0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0, 0, 0);
    hq_a = empty_q(3); hq_b = empty_q(5); cnt_a = 0; cnt_b = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_sel", a_sel, 0);
    check("reset_stall", a_stall, 0);
    check("reset_cnt", a_cnt, 0);

    // ALU chain: forward from stage 1, then from stage 2.
    alu_a(3); cycle();
    rd_a(3, 1, 0, 0); #1 check("alu_fwd1", a_sel[1:0], 1); check("alu_nostall", a_stall, 0); cycle();
    rd_a(3, 1, 0, 0); #1 check("alu_fwd2", a_sel[1:0], 2); cycle();

    // Load-use: one stall cycle, then forward from stage 2.
    set_a(1, 0, 0, 0, 0, 5, 1, 1); cycle();
    rd_a(0, 0, 5, 1); #1 check("lu_stall", a_stall, 1); check("lu_sel0", a_sel[3:2], 0); cycle();
    #1 check("lu_fwd", a_sel[3:2], 2); check("lu_go", a_stall, 0); check("lu_cnt", a_cnt, 1); cycle();

    // Youngest producer wins; r0 never hazards; no self-match.
    alu_a(7); cycle();
    set_a(0, 0, 0, 0, 0, 0, 0, 0); cycle();
    alu_a(7); cycle();
    rd_a(7, 1, 7, 1); #1 check("prio_sel", a_sel, 4'b0101); cycle();
    set_a(1, 0, 0, 0, 0, 0, 1, 1); cycle();
    rd_a(0, 1, 0, 1); #1 check("zero_sel", a_sel, 0); check("zero_stall", a_stall, 0); cycle();
    set_a(1, 9, 1, 0, 0, 9, 1, 0); #1 check("self_sel", a_sel, 0); cycle();

    // Freeze holds shadow and counter; flush beats the hazard.
    set_a(1, 0, 0, 0, 0, 6, 1, 1); cycle();
    for (int n = 0; n < 3; n++) begin
      set_a(1, 6, 1, 0, 0, 0, 0, 0, 0); #1 check("frz_stall", a_stall, 1); cycle();
    end
    #1 check("frz_cnt", a_cnt, 1);
    set_a(1, 6, 1, 0, 0, 0, 0, 0, 1, 1); #1 check("flush_stall", a_stall, 0); cycle();
    rd_a(6, 1, 0, 0); #1 check("post_flush_sel", a_sel[1:0], 2); check("post_flush_cnt", a_cnt, 1); cycle();

    // Counter saturates at 15; clear beats a same-cycle stall.
    for (int n = 0; n < 17; n++) begin
      set_a(1, 0, 0, 0, 0, 10, 1, 1); cycle();
      rd_a(10, 1, 0, 0); cycle();
      cycle();
    end
    #1 check("sat_cnt", a_cnt, 15);
    set_a(1, 0, 0, 0, 0, 10, 1, 1); cycle();
    set_a(1, 10, 1, 0, 0, 0, 0, 0, 1, 0, 1); #1 check("clr_stall", a_stall, 1); cycle();
    set_a(1, 10, 1, 0, 0, 0, 0, 0); #1 check("clr_cnt", a_cnt, 0); cycle();
    set_a(0, 0, 0, 0, 0, 0, 0, 0);

    // Wide configuration: load dependence stalls 3 cycles, then forwards from stage 4.
    set_b(1, 0, 0, 0, 3'b000, 4, 1, 1); cycle();
    set_b(1, 0, 0, 4, 3'b100, 0, 0, 0);
    for (int n = 0; n < 3; n++) begin
      #1 check("b_lu_stall", b_stall, 1); cycle();
    end
    #1 check("b_lu_fwd", b_sel[8:6], 4); check("b_lu_go", b_stall, 0); check("b_lu_cnt", b_cnt, 3); cycle();

    // Asynchronous reset in the middle of a stall.
    set_b(1, 0, 0, 0, 3'b000, 4, 1, 1); cycle();
    set_b(1, 4, 0, 0, 3'b001, 0, 0, 0); #1 check("b_pre_rst_stall", b_stall, 1);
    pulse_reset();
    #1 check("b_post_rst_stall", b_stall, 0);

    // Random traffic on both instances over a small register set to provoke hits.
    for (int n = 0; n < 400; n++) begin
      a_valid = ($urandom_range(0, 9) != 0);
      a_src   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      a_used  = 2'($urandom);
      a_dst   = 5'($urandom_range(0, 7));
      a_wr    = ($urandom_range(0, 3) != 0);
      a_ld    = ($urandom_range(0, 2) == 0);
      a_adv   = ($urandom_range(0, 7) != 0);
      a_flush = ($urandom_range(0, 9) == 0);
      a_clr   = ($urandom_range(0, 19) == 0);
      b_valid = ($urandom_range(0, 9) != 0);
      b_src   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      b_used  = 3'($urandom);
      b_dst   = 5'($urandom_range(0, 7));
      b_wr    = ($urandom_range(0, 3) != 0);
      b_ld    = ($urandom_range(0, 2) == 0);
      b_adv   = ($urandom_range(0, 7) != 0);
      b_flush = ($urandom_range(0, 9) == 0);
      b_clr   = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
